// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states and
// register window offsets.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap naturally because the
// depth is a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window feeding a
// byte FIFO drained by a bit-timing FSM with a registered serial output.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sel,
    output logic        txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitidx, bitidx_n;
    logic [7:0]    shift, shift_n;
    logic          txd_n;
    logic          ovf;

    logic [31:0]   ofs;
    logic          hit_tx, hit_st;
    logic          push, pop, full, empty, busy, cnt_last;
    logic [7:0]    head;
    logic [AW:0]   count;
    logic          unused;

    assign ofs    = {dataadr[31:2], 2'b00} - BASE_ADDR;
    assign hit_tx = (ofs == TXDATA_OFS);
    assign hit_st = (ofs == STATUS_OFS);
    assign sel    = hit_tx || hit_st;
    assign push   = memwrite && hit_tx && !full;
    assign busy   = (state != ST_IDLE);
    assign unused = ^{writedata[31:8], dataadr[1:0]};

    always_comb begin
        readdata = '0;
        if (hit_st)
            readdata = {16'h0, 8'(count), 4'h0, ovf, busy, empty, full};
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (writedata[7:0]),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A store that finds the FIFO full is lost even if a pop frees a slot on
    // the same edge; OVF remembers it until software writes STATUS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                ovf <= 1'b0;
        else if (memwrite && hit_tx && full)      ovf <= 1'b1;
        else if (memwrite && hit_st)              ovf <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shift  <= '0;
            txd    <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitidx <= bitidx_n;
            shift  <= shift_n;
            txd    <= txd_n;
        end
    end

    assign cnt_last = (cnt == CW'(CLKS_PER_BIT - 1));

    // txd_n is the line level for the state being entered, so txd changes
    // on the same edge as the state.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitidx_n = bitidx;
        shift_n  = shift;
        txd_n    = txd;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    cnt_n   = '0;
                    state_n = ST_START;
                    txd_n   = 1'b0;
                end
            end
            ST_START: begin
                cnt_n = cnt + CW'(1);
                if (cnt_last) begin
                    cnt_n    = '0;
                    bitidx_n = '0;
                    state_n  = ST_DATA;
                    txd_n    = shift[0];
                end
            end
            ST_DATA: begin
                cnt_n = cnt + CW'(1);
                if (cnt_last) begin
                    cnt_n = '0;
                    if (bitidx == 3'd7) begin
                        state_n = ST_STOP;
                        txd_n   = 1'b1;
                    end else begin
                        shift_n  = {1'b0, shift[7:1]};
                        bitidx_n = bitidx + 3'd1;
                        txd_n    = shift[1];
                    end
                end
            end
            ST_STOP: begin
                cnt_n = cnt + CW'(1);
                if (cnt_last) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    txd_n   = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and random stores checked every cycle
// against a frame-timeline reference model of the line and STATUS register.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr, writedata, readdata;
    logic        sel, txd;

    int checks = 0;
    int errors = 0;

    // reference model: queued bytes, frame in flight and its position
    logic [7:0] q[$];
    logic       m_busy;
    int         m_pos;
    logic [7:0] m_byte;
    logic       m_ovf;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(32'h0000_0100)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .sel       (sel),
        .txd       (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        q.delete();
        m_busy = 1'b0;
        m_pos  = 0;
        m_byte = 8'h00;
        m_ovf  = 1'b0;
    endtask

    function automatic logic exp_txd();
        int b;
        if (!m_busy) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [7:0] n;
        n = 8'(q.size());
        return {16'h0, n, 4'h0, m_ovf, m_busy, (q.size() == 0), (q.size() == DEPTH)};
    endfunction

    // One clock edge of the reference model, using pre-edge queue state.
    task automatic mdl_edge(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] a;
        logic        was_full;
        a = {adr[31:2], 2'b00};
        was_full = (q.size() == DEPTH);
        if (!m_busy) begin
            if (q.size() > 0) begin
                m_byte = q.pop_front();
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME) m_busy = 1'b0;
        end
        if (we && a == 32'h100) begin
            if (was_full) m_ovf = 1'b1;
            else          q.push_back(wd[7:0]);
        end
        if (we && a == 32'h104) m_ovf = 1'b0;
    endtask

    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        memwrite  = we;
        dataadr   = adr;
        writedata = wd;
        @(posedge clk);
        mdl_edge(we, adr, wd);
        #1;
        memwrite = 1'b0;
        dataadr  = 32'h104;
        #1;
        chk("txd", {31'h0, txd}, {31'h0, exp_txd()});
        chk("status", readdata, exp_status());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_txd", {31'h0, txd}, 32'h1);
        dataadr = 32'h104; #1;
        chk("rst_status", readdata, 32'h0000_0002);
        chk("sel_status", {31'h0, sel}, 32'h1);
        dataadr = 32'h107; #1;
        chk("status_lowbits", readdata, 32'h0000_0002);
        dataadr = 32'h108; #1;
        chk("sel_outside", {31'h0, sel}, 32'h0);
        chk("rd_outside", readdata, 32'h0);
        dataadr = 32'h0FC; #1;
        chk("sel_below", {31'h0, sel}, 32'h0);
        dataadr = 32'h100; #1;
        chk("sel_txdata", {31'h0, sel}, 32'h1);
        chk("rd_txdata", readdata, 32'h0);

        // single frame of 0xA5, upper data bits must be ignored
        step(1'b1, 32'h100, 32'hDEAD_BEA5);
        idle(FRAME + 4);

        // six stores: fifth fills, sixth overflows, STATUS write clears OVF
        for (int i = 0; i < 6; i++) step(1'b1, 32'h100, 32'h11 + i);
        step(1'b1, 32'h104, 32'hFFFF_FFFF);
        idle(5 * FRAME + 10);

        // two queued bytes back to back
        step(1'b1, 32'h101, 32'h3C);
        step(1'b1, 32'h102, 32'hC3);
        idle(2 * FRAME + 6);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 22)      step(1'b1, 32'h100 | 32'($urandom_range(0, 3)), $urandom);
            else if (r < 25) step(1'b1, 32'h104, $urandom);
            else if (r < 28) step(1'b1, 32'h108, $urandom);
            else             step(1'b0, $urandom, $urandom);
        end
        idle(DEPTH * FRAME + FRAME + 4);

        // reset during data bit 3
        step(1'b1, 32'h100, 32'h5A);
        for (int i = 0; i < 3 * FRAME && !(m_busy && m_pos == 4 * CPB + 1); i++)
            idle(1);
        chk("reached_bit3", {31'h0, (m_busy && m_pos == 4 * CPB + 1)}, 32'h1);
        reset = 1'b1;
        #1;
        chk("midframe_rst_txd", {31'h0, txd}, 32'h1);
        mdl_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        dataadr = 32'h104; #1;
        chk("post_rst_status", readdata, 32'h0000_0002);
        chk("post_rst_sel", {31'h0, sel}, 32'h1);
        idle(FRAME + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: TX byte FIFO entries; power of two, 2..64.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0100: word-aligned base of the 2-word register window.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 memwrite  input  1  processor store strobe, same cycle as dataadr/writedata.
REQ-007 dataadr  input  32  processor data address.
REQ-008 writedata  input  32  processor store data.
REQ-009 readdata  output  32  register read data, combinational from dataadr.
REQ-010 sel  output  1  high when dataadr hits the register window; used by top-level to mux readdata against dmem.
REQ-011 txd  output  1  serial line, idle high.

Function
REQ-012 Register map: TXDATA at BASE_ADDR+0, STATUS at BASE_ADDR+4; dataadr[1:0] ignored; other addresses: sel=0, readdata=0.
REQ-013 Store to TXDATA with FIFO not full SHALL push writedata[7:0] at that edge; upper bits ignored.
REQ-014 Store to TXDATA with FIFO full SHALL be dropped and set sticky OVF; no bypass, even if a pop occurs the same edge.
REQ-015 Store to STATUS (any data) SHALL clear OVF; an OVF-set and clear on the same edge cannot occur (different addresses).
REQ-016 STATUS read: bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVF, bits[15:8] FIFO count, other bits 0.
REQ-017 TXDATA read returns 0.
REQ-018 FIFO: count, read/write pointers wrap modulo FIFO_DEPTH; simultaneous push and pop when not full SHALL leave count unchanged.
REQ-019 FSM states IDLE, START, DATA, STOP.
REQ-020 IDLE: txd=1; on an edge with FIFO non-empty, pop head into shift register, clear baud counter, go START.
REQ-021 START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-022 DATA: txd=shift[0], LSB first, each bit held CLKS_PER_BIT cycles; after bit 7, go STOP.
REQ-023 STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-024 Latency: store to TXDATA at edge k into an empty FIFO with FSM idle -> txd falls at edge k+1; frame lasts exactly 10*CLKS_PER_BIT cycles.
REQ-025 Back-to-back: if FIFO non-empty at STOP exit, IDLE lasts exactly one cycle before next START.
REQ-026 txd SHALL be driven from a flop (glitch-free).
REQ-027 Baud counter width = $clog2(CLKS_PER_BIT); wraps to 0 at CLKS_PER_BIT-1.

Reset
REQ-028 Asserting reset at any time, including mid-frame, SHALL immediately force txd=1, FSM=IDLE, FIFO empty, OVF=0, counters 0.
REQ-029 A partially sent frame is abandoned; no resumption after reset deasserts.
REQ-030 readdata and sel remain combinational; after reset STATUS reads 32'h0000_0002.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum and register offset constants (TXDATA_OFS=0, STATUS_OFS=4).
REQ-032 FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width 8 and depth.
REQ-033 Instantiated alongside dmem in the processor top; readdata muxed by sel.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Store 32'h0000_00A5 to 0x100 -> txd low one cycle later for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high 4 cycles; BUSY clear after 40 cycles.
REQ-035 Five consecutive stores (0x11..0x15) while idle -> first pops immediately, remaining four fill FIFO, no OVF; six stores -> sixth dropped, STATUS bit3=1; store to 0x104 -> bit3=0.
REQ-036 Two queued bytes -> second START begins exactly one IDLE cycle after first STOP ends.
REQ-037 Assert reset during DATA bit 3 -> txd=1 same cycle, STATUS=0x0000_0002 after release, no further frame output.
REQ-038 Read 0x104 after reset -> 0x0000_0002, sel=1; read 0x108 -> sel=0, readdata=0.
